csr_access_ctrl: RTL and testbench

//  Sequences every access to the CSR file's single port (addr/wen/wdata/rdata).

---
 rtl/csr_pkg.sv | 42 ++++
 rtl/csr_rmw_alu.sv | 56 +++++
 rtl/csr_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_csr_access_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access path: Zicsr funct3 encodings,
// sequencer states, requester identity and the well-known CSR addresses.
package csr_pkg;

    localparam int CSR_XLEN   = 32;
    localparam int CSR_ADDR_W = 12;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } ctrl_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MISA      = 12'h301;
    localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE     = 12'hC00;
    localparam logic [CSR_ADDR_W-1:0] CSR_MVENDORID = 12'hF11;

    // funct3 000 and 100 are not CSR instructions.
    function automatic logic is_legal_op(input logic [2:0] op);
        return op[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Read-modify-write datapath: from the old CSR value and the request, produce
// the new value, whether the file is actually written, and the core error flag.
module csr_rmw_alu
    import csr_pkg::*;
#(
    parameter int XLEN   = CSR_XLEN,
    parameter int ADDR_W = CSR_ADDR_W
) (
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   old_val,
    input  logic [XLEN-1:0]   src,
    input  logic              is_dbg,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    output logic [XLEN-1:0]   new_val,
    output logic              do_write,
    output logic              err
);

    logic want_write;
    logic read_only;

    // NOTE: every output gets a default before the case, so no latch is inferred.
    always_comb begin
        new_val    = src;
        want_write = 1'b0;
        if (is_dbg) begin
            want_write = we;
        end else begin
            case (csr_op_e'(op))
                CSR_RW, CSR_RWI: begin
                    new_val    = src;
                    want_write = 1'b1;
                end
                CSR_RS, CSR_RSI: begin
                    new_val    = old_val | src;
                    want_write = |src;
                end
                CSR_RC, CSR_RCI: begin
                    new_val    = old_val & ~src;
                    want_write = |src;
                end
                default: begin
                    new_val    = src;
                    want_write = 1'b0;
                end
            endcase
        end
    end

    // Top quarter of the address map is read-only; debug writes there vanish quietly.
    assign read_only = addr[ADDR_W-1 -: 2] == 2'b11;
    assign do_write  = want_write & ~read_only;
    assign err       = ~is_dbg & want_write & read_only;

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequencer for the CSR file's single port: arbitrates core Zicsr ops against
// debug reads/writes and returns the pre-write CSR value to the winner.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN   = CSR_XLEN,
    parameter int ADDR_W = CSR_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              core_valid,
    output logic              core_ready,
    input  logic [2:0]        core_op,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [XLEN-1:0]   core_src,
    output logic              core_rsp_valid,
    output logic [XLEN-1:0]   core_rsp_rdata,
    output logic              core_rsp_err,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [XLEN-1:0]   dbg_wdata,
    output logic              dbg_rsp_valid,
    output logic [XLEN-1:0]   dbg_rsp_rdata,
    output logic [ADDR_W-1:0] csr_addr,
    output logic              csr_wen,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata
);

    ctrl_state_e       state;
    owner_e            last_grant;
    owner_e            owner;
    owner_e            grant_to;
    logic              ready_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   src_q;
    logic [XLEN-1:0]   old_q;
    logic              we_q;
    logic              err_q;
    logic              core_req;
    logic              dbg_req;
    logic [XLEN-1:0]   alu_new;
    logic              alu_do_write;
    logic              alu_err;

    assign core_ready = ready_q;
    assign dbg_ready  = ready_q;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        core_req = core_valid & ready_q;
        dbg_req  = dbg_valid & ready_q;
        grant_to = OWN_CORE;
        if (dbg_req && !(core_req && last_grant == OWN_DBG)) grant_to = OWN_DBG;
    end

    csr_rmw_alu #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_alu (
        .op       (op_q),
        .old_val  (csr_rdata),
        .src      (src_q),
        .is_dbg   (owner == OWN_DBG),
        .we       (we_q),
        .addr     (addr_q),
        .new_val  (alu_new),
        .do_write (alu_do_write),
        .err      (alu_err)
    );

    // NOTE: all state updates use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= ST_IDLE;
            last_grant     <= OWN_CORE;
            owner          <= OWN_CORE;
            ready_q        <= 1'b0;
            op_q           <= '0;
            addr_q         <= '0;
            src_q          <= '0;
            old_q          <= '0;
            we_q           <= 1'b0;
            err_q          <= 1'b0;
            core_rsp_valid <= 1'b0;
            core_rsp_rdata <= '0;
            core_rsp_err   <= 1'b0;
            dbg_rsp_valid  <= 1'b0;
            dbg_rsp_rdata  <= '0;
            csr_addr       <= '0;
            csr_wen        <= 1'b0;
            csr_wdata      <= '0;
        end else begin
            core_rsp_valid <= 1'b0;
            dbg_rsp_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (core_req || dbg_req) begin
                        last_grant <= grant_to;
                        owner      <= grant_to;
                        ready_q    <= 1'b0;
                        if (grant_to == OWN_CORE) begin
                            op_q   <= core_op;
                            addr_q <= core_addr;
                            src_q  <= core_src;
                            we_q   <= 1'b0;
                        end else begin
                            op_q   <= '0;
                            addr_q <= dbg_addr;
                            src_q  <= dbg_wdata;
                            we_q   <= dbg_we;
                        end
                        if (grant_to == OWN_CORE && !is_legal_op(core_op)) begin
                            state          <= ST_RESP;
                            core_rsp_valid <= 1'b1;
                            core_rsp_rdata <= '0;
                            core_rsp_err   <= 1'b1;
                        end else begin
                            state    <= ST_READ;
                            csr_addr <= (grant_to == OWN_CORE) ? core_addr : dbg_addr;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_READ: begin
                    old_q     <= csr_rdata;
                    err_q     <= alu_err;
                    csr_wen   <= alu_do_write;
                    csr_wdata <= alu_do_write ? alu_new : '0;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    csr_addr  <= '0;
                    csr_wen   <= 1'b0;
                    csr_wdata <= '0;
                    state     <= ST_RESP;
                    if (owner == OWN_CORE) begin
                        core_rsp_valid <= 1'b1;
                        core_rsp_rdata <= old_q;
                        core_rsp_err   <= err_q;
                    end else begin
                        dbg_rsp_valid <= 1'b1;
                        dbg_rsp_rdata <= old_q;
                    end
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: a CSR file model on the port, a transaction-level
// reference that predicts every output cycle, directed cases and random traffic.
module tb_csr_access_ctrl;
    import csr_pkg::*;

    localparam int MAXC = 4000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        core_valid = 1'b0, core_ready;
    logic [2:0]  core_op = '0;
    logic [11:0] core_addr = '0;
    logic [31:0] core_src = '0;
    logic        core_rsp_valid, core_rsp_err;
    logic [31:0] core_rsp_rdata;
    logic        dbg_valid = 1'b0, dbg_ready, dbg_we = 1'b0;
    logic [11:0] dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_rdata;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic [31:0] csr_wdata, csr_rdata;

    csr_access_ctrl dut (
        .clock(clock), .reset(reset),
        .core_valid(core_valid), .core_ready(core_ready), .core_op(core_op),
        .core_addr(core_addr), .core_src(core_src),
        .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata), .core_rsp_err(core_rsp_err),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
        .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_val(input logic [11:0] a);
        case (a)
            CSR_MCYCLE:    return 32'h0000_0C35;
            CSR_MISA:      return 32'h4000_1000;
            CSR_MVENDORID: return 32'h6265_6B61;
            default:       return {20'hC5A00, a};
        endcase
    endfunction

    // CSR file the DUT talks to: combinational read, write on the clock edge.
    logic [31:0] env_mem [4096];
    bit          env_loaded = 1'b0;
    assign csr_rdata = env_mem[csr_addr];
    always @(posedge clock) begin
        if (!env_loaded) begin
            for (int i = 0; i < 4096; i++) env_mem[i] <= init_val(12'(i));
            env_loaded <= 1'b1;
        end else if (csr_wen) begin
            env_mem[csr_addr] <= csr_wdata;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s @%0t: bounded wait expired", name, $time);
    endtask

    // Reference model: per-cycle expectations scheduled when a grant is predicted.
    typedef struct {
        logic        cv, dv, cerr, wen;
        logic [31:0] crd, drd, wdata;
        logic [11:0] addr;
    } exp_t;

    exp_t        exp_c [MAXC];
    logic [31:0] ref_mem [4096];
    int          cyc = 0;
    int          free_at = 0;
    bit          last_dbg = 1'b0;
    bit          armed = 1'b0;
    bit          core_gnt = 1'b0, dbg_gnt = 1'b0;
    int          rsp_log [$];

    task automatic model_grant(input bit to_dbg);
        logic [11:0] a;
        logic [31:0] s, old, nv;
        bit          wants, ro;
        a   = to_dbg ? dbg_addr : core_addr;
        s   = to_dbg ? dbg_wdata : core_src;
        old = ref_mem[a];
        if (!to_dbg && (core_op == 3'b000 || core_op == 3'b100)) begin
            exp_c[cyc+1].cv   = 1'b1;
            exp_c[cyc+1].crd  = '0;
            exp_c[cyc+1].cerr = 1'b1;
            free_at = cyc + 2;
            return;
        end
        if (to_dbg) begin
            nv = s;
            wants = dbg_we;
        end else begin
            case (core_op & 3'b011)
                3'b001:  begin nv = s;        wants = 1'b1;     end
                3'b010:  begin nv = old | s;  wants = (s != 0); end
                default: begin nv = old & ~s; wants = (s != 0); end
            endcase
        end
        ro = (a >= 12'hC00);
        exp_c[cyc+1].addr  = a;
        exp_c[cyc+2].addr  = a;
        exp_c[cyc+2].wen   = wants && !ro;
        exp_c[cyc+2].wdata = (wants && !ro) ? nv : 32'h0;
        if (to_dbg) begin
            exp_c[cyc+3].dv  = 1'b1;
            exp_c[cyc+3].drd = old;
        end else begin
            exp_c[cyc+3].cv   = 1'b1;
            exp_c[cyc+3].crd  = old;
            exp_c[cyc+3].cerr = wants && ro;
        end
        free_at = cyc + 4;
    endtask

    // Compare process: one sample per cycle, on the falling edge.
    initial begin
        bit to_dbg;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
        for (int i = 0; i < MAXC; i++) exp_c[i] = '{default: '0};
        forever begin
            @(negedge clock);
            core_gnt = 1'b0;
            dbg_gnt  = 1'b0;
            if (armed) begin
                check("core_ready", 32'(core_ready), 32'(cyc >= free_at));
                check("dbg_ready", 32'(dbg_ready), 32'(cyc >= free_at));
                check("core_rsp_valid", 32'(core_rsp_valid), 32'(exp_c[cyc].cv));
                check("dbg_rsp_valid", 32'(dbg_rsp_valid), 32'(exp_c[cyc].dv));
                check("csr_addr", 32'(csr_addr), 32'(exp_c[cyc].addr));
                check("csr_wen", 32'(csr_wen), 32'(exp_c[cyc].wen));
                check("csr_wdata", csr_wdata, exp_c[cyc].wdata);
                if (exp_c[cyc].cv) begin
                    check("core_rsp_rdata", core_rsp_rdata, exp_c[cyc].crd);
                    check("core_rsp_err", 32'(core_rsp_err), 32'(exp_c[cyc].cerr));
                end
                if (exp_c[cyc].dv) check("dbg_rsp_rdata", dbg_rsp_rdata, exp_c[cyc].drd);
                if (core_rsp_valid) rsp_log.push_back(0);
                if (dbg_rsp_valid) rsp_log.push_back(1);
            end
            if (exp_c[cyc].wen) ref_mem[exp_c[cyc].addr] = exp_c[cyc].wdata;
            if (!reset) begin
                armed = 1'b1;
                for (int k = 1; k <= 4; k++) exp_c[cyc+k] = '{default: '0};
                free_at  = cyc + 2;
                last_dbg = 1'b0;
            end else if (armed && cyc >= free_at && (core_valid || dbg_valid)) begin
                to_dbg   = dbg_valid && (!core_valid || !last_dbg);
                last_dbg = to_dbg;
                if (to_dbg) dbg_gnt = 1'b1;
                else core_gnt = 1'b1;
                model_grant(to_dbg);
            end
            cyc++;
            if (cyc + 5 >= MAXC) begin
                $display("FAIL cycle_budget: %0d cycles used", cyc);
                $fatal(1, "cycle budget exhausted");
            end
        end
    end

    task automatic wait_gnt(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clock);
            if (core_gnt || dbg_gnt) got = 1'b1;
        end
        if (!got) timeout(name);
    endtask

    task automatic request(input bit is_dbg, input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] data, input bit we,
                           output logic [31:0] rd, output logic err, output int lat);
        bit got = 1'b0;
        @(posedge clock);
        #1;
        if (is_dbg) begin
            dbg_valid = 1'b1; dbg_addr = addr; dbg_wdata = data; dbg_we = we;
        end else begin
            core_valid = 1'b1; core_op = op; core_addr = addr; core_src = data;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clock);
            if (is_dbg ? dbg_gnt : core_gnt) got = 1'b1;
        end
        #1;
        if (is_dbg) dbg_valid = 1'b0;
        else core_valid = 1'b0;
        rd = '0; err = 1'b0; lat = 0;
        if (!got) begin
            timeout("request_grant");
            return;
        end
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clock);
            if (is_dbg ? dbg_rsp_valid : core_rsp_valid) begin
                lat = n;
                rd  = is_dbg ? dbg_rsp_rdata : core_rsp_rdata;
                err = is_dbg ? 1'b0 : core_rsp_err;
            end
        end
        if (lat == 0) timeout("request_rsp");
    endtask

    function automatic logic [11:0] pick_addr();
        case ($urandom_range(0, 9))
            0: return CSR_MCYCLE;
            1: return CSR_MINSTRET;
            2: return CSR_MISA;
            3: return CSR_MSTATUS;
            4: return CSR_MSCRATCH;
            5: return CSR_MVENDORID;
            6: return CSR_CYCLE;
            7: return 12'hB82;
            8: return 12'h7B2;
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          n;

        repeat (4) @(posedge clock);
        #1 reset = 1'b1;

        // Core RW to mcycle: old value back three cycles after the grant.
        request(1'b0, 3'b001, CSR_MCYCLE, 32'h0000_1234, 1'b0, rd, err, lat);
        check("t1_rdata", rd, 32'h0000_0C35);
        check("t1_err", 32'(err), 32'h0);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_file", env_mem[CSR_MCYCLE], 32'h0000_1234);

        // Core RS with zero source reads without writing.
        request(1'b0, 3'b010, CSR_MISA, 32'h0, 1'b0, rd, err, lat);
        check("t2_rdata", rd, 32'h4000_1000);
        check("t2_err", 32'(err), 32'h0);
        check("t2_file", env_mem[CSR_MISA], 32'h4000_1000);

        // Clearing bits of a read-only CSR is an error; clearing nothing is not.
        request(1'b0, 3'b011, CSR_MVENDORID, 32'h0000_00FF, 1'b0, rd, err, lat);
        check("t3_rdata", rd, 32'h6265_6B61);
        check("t3_err", 32'(err), 32'h1);
        request(1'b0, 3'b011, CSR_MVENDORID, 32'h0, 1'b0, rd, err, lat);
        check("t3b_err", 32'(err), 32'h0);
        check("t3b_file", env_mem[CSR_MVENDORID], 32'h6265_6B61);

        // Illegal funct3 values answer in one cycle with an error.
        request(1'b0, 3'b000, CSR_MSCRATCH, 32'h5, 1'b0, rd, err, lat);
        check("ill0_err", 32'(err), 32'h1);
        check("ill0_latency", 32'(lat), 32'd1);
        request(1'b0, 3'b100, CSR_MSCRATCH, 32'h5, 1'b0, rd, err, lat);
        check("ill4_rdata", rd, 32'h0);
        check("ill4_err", 32'(err), 32'h1);

        // Debug write then read back; debug write to read-only space is dropped.
        request(1'b1, 3'b000, 12'hB82, 32'hA5A5_A5A5, 1'b1, rd, err, lat);
        check("t5_wr_rdata", rd, 32'hC5A0_0B82);
        request(1'b1, 3'b000, 12'hB82, 32'h0, 1'b0, rd, err, lat);
        check("t5_rd_rdata", rd, 32'hA5A5_A5A5);
        request(1'b1, 3'b000, CSR_CYCLE, 32'hDEAD_BEEF, 1'b1, rd, err, lat);
        request(1'b1, 3'b000, CSR_CYCLE, 32'h0, 1'b0, rd, err, lat);
        check("ro_dbg_rdata", rd, 32'hC5A0_0C00);

        // Arbitration: from reset debug wins a tie, then it alternates.
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        rsp_log.delete();
        core_valid = 1'b1; core_op = 3'b001; core_addr = CSR_MSCRATCH; core_src = 32'h11;
        dbg_valid  = 1'b1; dbg_we = 1'b0; dbg_addr = CSR_MISA;
        wait_gnt("t4_gnt1");
        check("t4_gnt1_dbg", {30'h0, core_gnt, dbg_gnt}, 32'b01);
        #1 dbg_addr = CSR_MCYCLE;
        wait_gnt("t4_gnt2");
        check("t4_gnt2_core", {30'h0, core_gnt, dbg_gnt}, 32'b10);
        #1 core_valid = 1'b0;
        wait_gnt("t4_gnt3");
        check("t4_gnt3_dbg", {30'h0, core_gnt, dbg_gnt}, 32'b01);
        #1 dbg_valid = 1'b0;
        repeat (6) @(posedge clock);
        check("t4_rsp_count", 32'(rsp_log.size()), 32'd3);
        if (rsp_log.size() == 3) begin
            check("t4_order0", 32'(rsp_log[0]), 32'd1);
            check("t4_order1", 32'(rsp_log[1]), 32'd0);
            check("t4_order2", 32'(rsp_log[2]), 32'd1);
        end

        // Reset while the write is on the port abandons the request.
        @(posedge clock); #1;
        core_valid = 1'b1; core_op = 3'b001; core_addr = CSR_MSCRATCH; core_src = 32'h77;
        wait_gnt("t6_gnt");
        #1 core_valid = 1'b0;
        rsp_log.delete();
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("t6_wen_after_reset", 32'(csr_wen), 32'h0);
        n = 1;
        while (!core_ready && n < 6) begin
            @(negedge clock);
            n++;
        end
        check("t6_ready_delay", 32'(n), 32'd2);
        repeat (6) @(posedge clock);
        check("t6_no_rsp", 32'(rsp_log.size()), 32'd0);

        // Random traffic from both requesters with occasional resets.
        for (int t = 0; t < 1500; t++) begin
            @(posedge clock);
            #1;
            if (core_valid && core_gnt) core_valid = 1'b0;
            else if (!core_valid && $urandom_range(0, 2) == 0) begin
                core_valid = 1'b1;
                core_op    = 3'($urandom_range(0, 7));
                core_addr  = pick_addr();
                core_src   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            end
            if (dbg_valid && dbg_gnt) dbg_valid = 1'b0;
            else if (!dbg_valid && $urandom_range(0, 3) == 0) begin
                dbg_valid = 1'b1;
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = pick_addr();
                dbg_wdata = $urandom;
            end
            reset = ($urandom_range(0, 199) != 0);
        end
        @(posedge clock);
        #1;
        reset = 1'b1; core_valid = 1'b0; dbg_valid = 1'b0;
        repeat (10) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
